// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port arbiter sharing one combinational ALU with issue/response stages and NZCV flag register
module alu_arbiter (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ0_VALID,
    output logic        REQ0_READY,
    input  logic [8:0]  REQ0_CTRL,
    input  logic [31:0] REQ0_A,
    input  logic [31:0] REQ0_B,
    input  logic        REQ0_SETF,
    input  logic        REQ0_LOCK,
    input  logic        REQ1_VALID,
    output logic        REQ1_READY,
    input  logic [8:0]  REQ1_CTRL,
    input  logic [31:0] REQ1_A,
    input  logic [31:0] REQ1_B,
    input  logic        REQ1_SETF,
    input  logic        REQ1_LOCK,
    output logic [8:0]  ALU_CTRL,
    output logic [31:0] ALU_A,
    output logic [31:0] ALU_B,
    input  logic [31:0] ALU_RESULT,
    input  logic [3:0]  ALU_FLAG,
    output logic        RSP0_VALID,
    output logic        RSP1_VALID,
    output logic [31:0] RSP_RESULT,
    output logic [3:0]  RSP_FLAG,
    output logic [3:0]  FLAG_REG
);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED0  = 2'd1,
        LOCKED1  = 2'd2
    } lock_t;

    localparam logic [8:0] CTRL_IDLE = 9'h007;

    lock_t       lock_q;
    lock_t       lock_d;
    logic        rr_q;
    logic        rr_d;
    logic        grant0;
    logic        grant1;
    logic        accept;
    logic        acc_port;
    logic        acc_lock;
    logic [8:0]  acc_ctrl;
    logic [31:0] acc_a;
    logic [31:0] acc_b;
    logic        acc_setf;

    logic        iss_valid;
    logic        iss_port;
    logic        iss_setf;
    logic [8:0]  iss_ctrl;
    logic [31:0] iss_a;
    logic [31:0] iss_b;

    // Grant is purely combinational; reset masks it so nothing is accepted in a reset cycle.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!RST) begin
            case (lock_q)
                LOCKED0: grant0 = REQ0_VALID;
                LOCKED1: grant1 = REQ1_VALID;
                default: begin
                    if (REQ0_VALID && REQ1_VALID) begin
                        grant0 = !rr_q;
                        grant1 = rr_q;
                    end else begin
                        grant0 = REQ0_VALID;
                        grant1 = REQ1_VALID;
                    end
                end
            endcase
        end
    end

    assign REQ0_READY = grant0;
    assign REQ1_READY = grant1;
    assign accept     = grant0 | grant1;
    assign acc_port   = grant1;

    always_comb begin
        acc_ctrl = REQ0_CTRL;
        acc_a    = REQ0_A;
        acc_b    = REQ0_B;
        acc_setf = REQ0_SETF;
        acc_lock = REQ0_LOCK;
        if (acc_port) begin
            acc_ctrl = REQ1_CTRL;
            acc_a    = REQ1_A;
            acc_b    = REQ1_B;
            acc_setf = REQ1_SETF;
            acc_lock = REQ1_LOCK;
        end
    end

    // Lock and round-robin pointer advance only on an accept.
    always_comb begin
        lock_d = lock_q;
        rr_d   = rr_q;
        if (accept) begin
            rr_d = ~acc_port;
            case (lock_q)
                LOCKED0, LOCKED1: begin
                    if (!acc_lock) begin
                        lock_d = UNLOCKED;
                    end
                end
                default: begin
                    if (acc_lock) begin
                        lock_d = acc_port ? LOCKED1 : LOCKED0;
                    end else begin
                        lock_d = UNLOCKED;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            lock_q    <= UNLOCKED;
            rr_q      <= 1'b0;
            iss_valid <= 1'b0;
            iss_port  <= 1'b0;
            iss_setf  <= 1'b0;
            iss_ctrl  <= CTRL_IDLE;
            iss_a     <= 32'd0;
            iss_b     <= 32'd0;
        end else begin
            lock_q    <= lock_d;
            rr_q      <= rr_d;
            iss_valid <= accept;
            if (accept) begin
                iss_port <= acc_port;
                iss_setf <= acc_setf;
                iss_ctrl <= acc_ctrl;
                iss_a    <= acc_a;
                iss_b    <= acc_b;
            end
        end
    end

    // Idle bus selects the zero result so the ALU output is quiet between operations.
    assign ALU_CTRL = iss_valid ? iss_ctrl : CTRL_IDLE;
    assign ALU_A    = iss_valid ? iss_a : 32'd0;
    assign ALU_B    = iss_valid ? iss_b : 32'd0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            RSP0_VALID <= 1'b0;
            RSP1_VALID <= 1'b0;
            RSP_RESULT <= 32'd0;
            RSP_FLAG   <= 4'd0;
            FLAG_REG   <= 4'd0;
        end else begin
            RSP0_VALID <= iss_valid && !iss_port;
            RSP1_VALID <= iss_valid && iss_port;
            if (iss_valid) begin
                RSP_RESULT <= ALU_RESULT;
                RSP_FLAG   <= ALU_FLAG;
                if (iss_setf) begin
                    FLAG_REG <= ALU_FLAG;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with a behavioural ALU on the bus
module tb_alu_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        REQ0_VALID, REQ0_READY, REQ0_SETF, REQ0_LOCK;
    logic [8:0]  REQ0_CTRL;
    logic [31:0] REQ0_A, REQ0_B;
    logic        REQ1_VALID, REQ1_READY, REQ1_SETF, REQ1_LOCK;
    logic [8:0]  REQ1_CTRL;
    logic [31:0] REQ1_A, REQ1_B;
    logic [8:0]  ALU_CTRL;
    logic [31:0] ALU_A, ALU_B, ALU_RESULT;
    logic [3:0]  ALU_FLAG;
    logic        RSP0_VALID, RSP1_VALID;
    logic [31:0] RSP_RESULT;
    logic [3:0]  RSP_FLAG, FLAG_REG;

    alu_arbiter dut (
        .CLK(CLK), .RST(RST),
        .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_CTRL(REQ0_CTRL),
        .REQ0_A(REQ0_A), .REQ0_B(REQ0_B), .REQ0_SETF(REQ0_SETF), .REQ0_LOCK(REQ0_LOCK),
        .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_CTRL(REQ1_CTRL),
        .REQ1_A(REQ1_A), .REQ1_B(REQ1_B), .REQ1_SETF(REQ1_SETF), .REQ1_LOCK(REQ1_LOCK),
        .ALU_CTRL(ALU_CTRL), .ALU_A(ALU_A), .ALU_B(ALU_B),
        .ALU_RESULT(ALU_RESULT), .ALU_FLAG(ALU_FLAG),
        .RSP0_VALID(RSP0_VALID), .RSP1_VALID(RSP1_VALID),
        .RSP_RESULT(RSP_RESULT), .RSP_FLAG(RSP_FLAG), .FLAG_REG(FLAG_REG)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        port;
        logic [31:0] res;
        logic [3:0]  flg;
        logic        setf;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic [3:0]  flag_exp = 4'd0;
    logic        g0, g1;
    logic [35:0] alu_out;

    task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Returns {N,Z,C,V,result}.
    function automatic logic [35:0] alu_f(input logic [8:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] r, x, y;
        logic        cf, vf, ci;
        cf = 1'b0;
        vf = 1'b0;
        case (c[2:0])
            3'd0: begin
                x  = c[6] ? b : a;
                y  = c[7] ? ~b : (c[6] ? ~a : b);
                ci = (c[7] | c[6]) ? 1'b1 : c[5];
                s  = {1'b0, x} + {1'b0, y} + {32'd0, ci};
                r  = s[31:0];
                cf = s[32];
                vf = (x[31] == y[31]) && (r[31] != x[31]);
            end
            3'd1: r = a & (c[8] ? ~b : b);
            3'd2: r = a | b;
            3'd3: r = a ^ b;
            3'd4: r = a >> b[4:0];
            3'd5: r = a << b[4:0];
            3'd6: r = b;
            default: r = 32'd0;
        endcase
        return {r[31], (r == 32'd0), cf, vf, r};
    endfunction

    assign alu_out    = alu_f(ALU_CTRL, ALU_A, ALU_B);
    assign ALU_RESULT = alu_out[31:0];
    assign ALU_FLAG   = {alu_out[35], alu_out[34], alu_out[33], alu_out[32]};

    always @(posedge CLK) cyc++;

    // Scoreboard: pop/compare responses, then push newly accepted operations.
    always @(negedge CLK) begin
        if (RST) begin
            sb.delete();
            flag_exp = 4'd0;
        end else begin
            check("ready_onehot", 36'(REQ0_READY & REQ1_READY), 36'd0);
            if (RSP0_VALID || RSP1_VALID) begin
                check("rsp_onehot", 36'(RSP0_VALID & RSP1_VALID), 36'd0);
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 36'({RSP1_VALID, RSP0_VALID}), 36'd0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_port", 36'(RSP1_VALID), 36'(e.port));
                    check("rsp_result", 36'(RSP_RESULT), 36'(e.res));
                    check("rsp_flag", 36'(RSP_FLAG), 36'(e.flg));
                    check("rsp_latency", 36'(cyc - e.cyc), 36'd2);
                    if (e.setf) flag_exp = e.flg;
                    check("flag_reg", 36'(FLAG_REG), 36'(flag_exp));
                end
            end else if (sb.size() > 0 && (cyc - sb[0].cyc) > 2) begin
                e = sb.pop_front();
                check("rsp_missing", 36'({RSP1_VALID, RSP0_VALID}), e.port ? 36'd2 : 36'd1);
            end
            if (REQ0_READY) begin
                e.port = 1'b0; e.setf = REQ0_SETF; e.cyc = cyc;
                {e.flg, e.res} = alu_f(REQ0_CTRL, REQ0_A, REQ0_B);
                sb.push_back(e);
            end
            if (REQ1_READY) begin
                e.port = 1'b1; e.setf = REQ1_SETF; e.cyc = cyc;
                {e.flg, e.res} = alu_f(REQ1_CTRL, REQ1_A, REQ1_B);
                sb.push_back(e);
            end
        end
    end

    task automatic drive(input int p, input logic v, input logic [8:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic s, input logic l);
        if (p == 0) begin
            REQ0_VALID = v; REQ0_CTRL = c; REQ0_A = a; REQ0_B = b; REQ0_SETF = s; REQ0_LOCK = l;
        end else begin
            REQ1_VALID = v; REQ1_CTRL = c; REQ1_A = a; REQ1_B = b; REQ1_SETF = s; REQ1_LOCK = l;
        end
    endtask

    task automatic step();
        @(negedge CLK);
        g0 = REQ0_READY;
        g1 = REQ1_READY;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        drive(0, 1'b0, 9'h007, 32'd0, 32'd0, 1'b0, 1'b0);
        drive(1, 1'b0, 9'h007, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic reset_pulse();
        RST = 1'b1;
        idle();
        step();
        RST = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        drive(0, 1'b1, 9'h000, 32'd1, 32'd2, 1'b0, 1'b0);
        drive(1, 1'b1, 9'h000, 32'd3, 32'd4, 1'b0, 1'b0);
        @(posedge CLK);
        #1;
        step();
        check("rst_ready", 36'({g1, g0}), 36'd0);
        check("rst_alu_ctrl", 36'(ALU_CTRL), 36'h007);
        check("rst_alu_ab", 36'(ALU_A | ALU_B), 36'd0);
        check("rst_rsp", 36'({RSP_FLAG, RSP_RESULT}), 36'd0);
        check("rst_flag_reg", 36'(FLAG_REG), 36'd0);
        check("rst_rsp_valid", 36'({RSP1_VALID, RSP0_VALID}), 36'd0);
        RST = 1'b0;
        idle();

        // Single add from port 0
        drive(0, 1'b1, 9'h000, 32'd5, 32'd7, 1'b1, 1'b0);
        step();
        check("t1_ready", 36'({g1, g0}), 36'b01);
        idle();
        check("t1_alu_ctrl", 36'(ALU_CTRL), 36'h000);
        check("t1_alu_a", 36'(ALU_A), 36'd5);
        step();
        check("t1_rsp0", 36'({RSP1_VALID, RSP0_VALID}), 36'b01);
        check("t1_result", 36'(RSP_RESULT), 36'd12);
        check("t1_flag", 36'(FLAG_REG), 36'd0);

        // Round robin with both valid
        reset_pulse();
        drive(0, 1'b1, 9'h006, $urandom, 32'd0, 1'b0, 1'b0);
        drive(1, 1'b1, 9'h006, $urandom, 32'd1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("t2_grant", 36'({g1, g0}), (i % 2 == 1) ? 36'b10 : 36'b01);
        end
        idle();
        step();
        step();

        // Lock held by port 1 across an idle cycle
        drive(0, 1'b1, 9'h002, 32'h0f0, 32'h00f, 1'b0, 1'b0);
        step();
        check("t3_pre", 36'({g1, g0}), 36'b01);
        drive(1, 1'b1, 9'h001, 32'hff00, 32'h0ff0, 1'b0, 1'b1);
        step();
        check("t3_lock", 36'({g1, g0}), 36'b10);
        drive(1, 1'b0, 9'h000, 32'd0, 32'd0, 1'b0, 1'b0);
        step();
        check("t3_lock_idle", 36'({g1, g0}), 36'b00);
        drive(1, 1'b1, 9'h003, 32'h1234, 32'h4321, 1'b1, 1'b1);
        step();
        check("t3_lock2", 36'({g1, g0}), 36'b10);
        drive(1, 1'b1, 9'h004, 32'h8000_0000, 32'd4, 1'b0, 1'b0);
        step();
        check("t3_unlock_op", 36'({g1, g0}), 36'b10);
        drive(1, 1'b1, 9'h005, 32'd1, 32'd31, 1'b0, 1'b0);
        step();
        check("t3_release", 36'({g1, g0}), 36'b01);
        idle();
        step();
        step();
        step();

        // Subtract sets Z, following xor leaves it untouched
        drive(0, 1'b1, 9'h080, 32'd3, 32'd3, 1'b1, 1'b0);
        step();
        drive(0, 1'b1, 9'h003, 32'd5, 32'd6, 1'b0, 1'b0);
        step();
        idle();
        check("t4_z", 36'(FLAG_REG[2]), 36'd1);
        step();
        check("t4_z_hold", 36'(FLAG_REG[2]), 36'd1);
        step();

        // Random traffic
        for (int i = 0; i < 40; i++) begin
            drive(0, 1'($urandom_range(0, 1)), 9'($urandom), $urandom, $urandom,
                  1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
            drive(1, 1'($urandom_range(0, 1)), 9'($urandom), $urandom, $urandom,
                  1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
            step();
        end
        drive(0, 1'b1, 9'h000, 32'd1, 32'd1, 1'b0, 1'b0);
        drive(1, 1'b1, 9'h000, 32'd2, 32'd2, 1'b0, 1'b0);
        step();
        step();
        idle();
        step();
        step();

        // Reset in the cycle after an accept
        drive(0, 1'b1, 9'h080, 32'd3, 32'd3, 1'b1, 1'b0);
        step();
        check("t5_sub", 36'({g1, g0}), 36'b01);
        drive(0, 1'b0, 9'h000, 32'd0, 32'd0, 1'b0, 1'b0);
        drive(1, 1'b1, 9'h000, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1);
        step();
        check("t5_accept", 36'({g1, g0}), 36'b10);
        check("t5_flag_pre", 36'(FLAG_REG), 36'b0110);
        RST = 1'b1;
        drive(0, 1'b1, 9'h000, 32'd9, 32'd9, 1'b0, 1'b0);
        step();
        check("t5_ready_rst", 36'({g1, g0}), 36'b00);
        RST = 1'b0;
        check("t5_rsp_valid", 36'({RSP1_VALID, RSP0_VALID}), 36'd0);
        check("t5_flag", 36'(FLAG_REG), 36'd0);
        check("t5_alu_ctrl", 36'(ALU_CTRL), 36'h007);
        check("t5_alu_a", 36'(ALU_A), 36'd0);
        drive(1, 1'b1, 9'h000, 32'd1, 32'd2, 1'b0, 1'b0);
        step();
        check("t5_prio", 36'({g1, g0}), 36'b01);
        idle();
        step();
        step();
        step();
        step();

        check("sb_empty", 36'(sb.size()), 36'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
